// File: rtl/common_pkg.sv
// Shared bus payload types and encodings for the core-side instruction bus
// (ibus) and the arbiter-side cache bus (cbus).
package common;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned CDATA_W = 64;
    localparam int unsigned IDATA_W = 32;

    typedef logic [2:0] msize_t;
    typedef logic [7:0] mlen_t;
    typedef logic [1:0] axi_burst_t;

    localparam msize_t MSIZE1 = 3'd0;
    localparam msize_t MSIZE2 = 3'd1;
    localparam msize_t MSIZE4 = 3'd2;
    localparam msize_t MSIZE8 = 3'd3;

    // AXI-style length encoding: beats - 1
    localparam mlen_t MLEN1  = 8'd0;
    localparam mlen_t MLEN2  = 8'd1;
    localparam mlen_t MLEN4  = 8'd3;
    localparam mlen_t MLEN8  = 8'd7;
    localparam mlen_t MLEN16 = 8'd15;

    localparam axi_burst_t AXI_BURST_FIXED = 2'd0;
    localparam axi_burst_t AXI_BURST_INCR  = 2'd1;
    localparam axi_burst_t AXI_BURST_WRAP  = 2'd2;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic               addr_ok;
        logic               data_ok;
        logic [IDATA_W-1:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        msize_t                 size;
        logic [ADDR_W-1:0]      addr;
        logic [CDATA_W/8-1:0]   strobe;
        logic [CDATA_W-1:0]     data;
        mlen_t                  len;
        axi_burst_t             burst;
    } cbus_req_t;

    typedef struct packed {
        logic               ready;
        logic               last;
        logic [CDATA_W-1:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/icache_pkg.sv
// Cache-local constants and the 32-bit half selector used on every read path.
package icache_pkg;

    localparam int unsigned BEAT_W = 64;
    localparam int unsigned WORD_W = 32;

    // Pick the upper or lower 32-bit instruction word of a 64-bit beat
    function automatic logic [WORD_W-1:0] pick_half(input logic [BEAT_W-1:0] beat,
                                                    input logic              hi);
        return hi ? beat[BEAT_W-1:WORD_W] : beat[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/icache_ram.sv
// Direct-mapped line storage: NSETS lines of data + tag + valid.
// Ports: clk/reset; i_flush clears every valid bit; one write port
// (i_we, i_wvalid, i_widx, i_wtag, i_wdata); one asynchronous read port
// (i_ridx -> o_rvalid, o_rtag, o_rdata).
module icache_ram #(
    parameter int unsigned NSETS  = 16,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned TAG_W  = 23,
    parameter int unsigned IDX_W  = $clog2(NSETS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_we,
    input  logic              i_wvalid,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [TAG_W-1:0]  i_wtag,
    input  logic [LINE_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic              o_rvalid,
    output logic [TAG_W-1:0]  o_rtag,
    output logic [LINE_W-1:0] o_rdata
);

    logic [NSETS-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [NSETS];
    logic [LINE_W-1:0] r_data [NSETS];

    // Valid bits: flush clears all; a write in the same cycle then sets its own bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= '0;
            end
            if (i_we) begin
                r_valid[i_widx] <= i_wvalid;
            end
        end
    end

    // Tag and data arrays carry no reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_wdata;
        end
    end

    assign o_rvalid = r_valid[i_ridx];
    assign o_rtag   = r_tag[i_ridx];
    assign o_rdata  = r_data[i_ridx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, blocking instruction cache between the core fetch port
// and the cbus arbiter.
// Ports: clk, reset (async, active-high); ireq/iresp core fetch interface
// (hits answered combinationally in IDLE); flush invalidates all lines;
// creq/cresp refill and uncached single-beat bus interface.
module icache
    import common::*;
    import icache_pkg::*;
#(
    parameter int unsigned NSETS      = 16,
    parameter int unsigned LINE_BEATS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  logic       flush,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);

    localparam int unsigned IDX_W  = $clog2(NSETS);
    localparam int unsigned CNT_W  = $clog2(LINE_BEATS);
    localparam int unsigned OFF_W  = 3 + CNT_W;
    localparam int unsigned TAG_W  = 32 - OFF_W - IDX_W;
    localparam int unsigned LINE_W = BEAT_W * LINE_BEATS;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REFILL   = 2'd1;
    localparam logic [1:0] S_UNCACHED = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    cbus_req_t         r_creq;
    cbus_req_t         w_creq_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_flushed;
    logic              r_uncached;
    logic [LINE_W-1:0] r_line;
    logic [BEAT_W-1:0] r_uc_beat;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [CNT_W-1:0]  w_word;
    logic              w_hi;
    logic              w_cacheable;
    logic              w_rvalid;
    logic [TAG_W-1:0]  w_rtag;
    logic [LINE_W-1:0] w_rline;
    logic              w_hit;
    logic [BEAT_W-1:0] w_hit_beat;
    logic [BEAT_W-1:0] w_buf_beat;
    logic [LINE_W-1:0] w_fill;
    logic              w_we;
    logic              w_beat_end;

    // Address decode of the (held) request
    assign w_idx       = ireq.addr[OFF_W +: IDX_W];
    assign w_tag       = ireq.addr[OFF_W + IDX_W +: TAG_W];
    assign w_word      = ireq.addr[3 +: CNT_W];
    assign w_hi        = ireq.addr[2];
    assign w_cacheable = ireq.addr[31];
    assign w_beat_end  = cresp.ready && cresp.last;

    assign w_hit      = w_cacheable && w_rvalid && (w_rtag == w_tag);
    assign w_hit_beat = w_rline[32'(w_word) * BEAT_W +: BEAT_W];
    assign w_buf_beat = r_line[32'(w_word) * BEAT_W +: BEAT_W];

    // Line written to the array includes the final beat arriving this cycle
    always_comb begin
        w_fill = r_line;
        w_fill[32'(r_cnt) * BEAT_W +: BEAT_W] = cresp.data;
    end

    icache_ram #(
        .NSETS  (NSETS),
        .LINE_W (LINE_W),
        .TAG_W  (TAG_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .i_flush  (flush),
        .i_we     (w_we),
        .i_wvalid (!(flush || r_flushed)),
        .i_widx   (w_idx),
        .i_wtag   (w_tag),
        .i_wdata  (w_fill),
        .i_ridx   (w_idx),
        .o_rvalid (w_rvalid),
        .o_rtag   (w_rtag),
        .o_rdata  (w_rline)
    );

    // Next-state, bus request and core response
    always_comb begin
        w_state_nxt = r_state;
        w_creq_nxt  = r_creq;
        iresp       = '0;
        w_we        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ireq.valid) begin
                    if (w_cacheable && w_hit) begin
                        iresp.addr_ok = 1'b1;
                        iresp.data_ok = 1'b1;
                        iresp.data    = pick_half(w_hit_beat, w_hi);
                    end else if (w_cacheable) begin
                        w_state_nxt      = S_REFILL;
                        w_creq_nxt       = '0;
                        w_creq_nxt.valid = 1'b1;
                        w_creq_nxt.size  = MSIZE8;
                        w_creq_nxt.len   = mlen_t'(LINE_BEATS - 1);
                        w_creq_nxt.burst = AXI_BURST_INCR;
                        w_creq_nxt.addr  = {ireq.addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    end else begin
                        w_state_nxt      = S_UNCACHED;
                        w_creq_nxt       = '0;
                        w_creq_nxt.valid = 1'b1;
                        w_creq_nxt.size  = MSIZE4;
                        w_creq_nxt.len   = MLEN1;
                        w_creq_nxt.burst = AXI_BURST_FIXED;
                        w_creq_nxt.addr  = ireq.addr;
                    end
                end
            end
            S_REFILL: begin
                if (w_beat_end) begin
                    w_we        = 1'b1;
                    w_state_nxt = S_DONE;
                    w_creq_nxt  = '0;
                end
            end
            S_UNCACHED: begin
                if (w_beat_end) begin
                    w_state_nxt = S_DONE;
                    w_creq_nxt  = '0;
                end
            end
            S_DONE: begin
                iresp.addr_ok = 1'b1;
                iresp.data_ok = 1'b1;
                iresp.data    = r_uncached ? pick_half(r_uc_beat, w_hi)
                                           : pick_half(w_buf_beat, w_hi);
                w_state_nxt   = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_creq_nxt  = '0;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_creq     <= '0;
            r_cnt      <= '0;
            r_flushed  <= 1'b0;
            r_uncached <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_creq  <= w_creq_nxt;
            if (r_state == S_IDLE) begin
                r_cnt     <= '0;
                r_flushed <= 1'b0;
                if (ireq.valid) begin
                    r_uncached <= !w_cacheable;
                end
            end
            if (r_state == S_REFILL) begin
                if (cresp.ready) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                // Remember a flush seen mid-burst so the line lands invalid
                if (flush) begin
                    r_flushed <= 1'b1;
                end
            end
        end
    end

    // Line assembly buffer and uncached word latch
    always_ff @(posedge clk) begin
        if ((r_state == S_REFILL) && cresp.ready) begin
            r_line[32'(r_cnt) * BEAT_W +: BEAT_W] <= cresp.data;
        end
        if ((r_state == S_UNCACHED) && w_beat_end) begin
            r_uc_beat <= cresp.data;
        end
    end

    assign creq = r_creq;

endmodule

// File: tb/tb_icache.sv
module tb_icache;
    import common::*;

    logic       clk;
    logic       reset;
    logic       flush;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [63:0] A0 = 64'h1100_0001_1100_0000;
    localparam logic [63:0] A1 = 64'h2200_0003_2200_0002;
    localparam logic [63:0] A2 = 64'h3300_0005_3300_0004;
    localparam logic [63:0] A3 = 64'h4400_0007_4400_0006;
    localparam logic [63:0] C0 = 64'h5500_0009_5500_0008;
    localparam logic [63:0] C1 = 64'h6600_000B_6600_000A;
    localparam logic [63:0] C2 = 64'h7700_000D_7700_000C;
    localparam logic [63:0] C3 = 64'h8800_000F_8800_000E;
    localparam logic [63:0] D0 = 64'h9900_0011_9900_0010;
    localparam logic [63:0] D1 = 64'hAA00_0013_AA00_0012;
    localparam logic [63:0] D2 = 64'hBB00_0015_BB00_0014;
    localparam logic [63:0] D3 = 64'hCC00_0017_CC00_0016;

    icache dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .flush (flush),
        .creq  (creq),
        .cresp (cresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_creq(input string tag);
        int k;
        k = 0;
        while (!creq.valid && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        chk(tag, 64'(creq.valid), 64'd1);
    endtask

    task automatic check_resp_zero(input string tag);
        chk(tag, 64'({iresp.addr_ok, iresp.data_ok, iresp.data}), 64'd0);
    endtask

    // Cacheable miss: checks request fields, feeds four beats, checks DONE response
    task automatic fill(input logic [63:0] a,
                        input logic [63:0] b0, input logic [63:0] b1,
                        input logic [63:0] b2, input logic [63:0] b3,
                        input int gaps, input int flush_beat,
                        input logic [31:0] exp);
        logic [63:0] b [4];
        logic [63:0] line_addr;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        line_addr = {a[63:5], 5'b0};
        @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = a;
        #1;
        chk("miss_no_resp", 64'(iresp.data_ok), 64'd0);
        wait_creq("refill_req_valid");
        chk("refill_addr",  creq.addr, line_addr);
        chk("refill_size",  64'(creq.size), 64'(MSIZE8));
        chk("refill_len",   64'(creq.len), 64'(MLEN4));
        chk("refill_burst", 64'(creq.burst), 64'(AXI_BURST_INCR));
        chk("refill_wr",    64'({creq.is_write, creq.strobe}), 64'd0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gaps; g++) begin
                    @(posedge clk); #1;
                    chk("gap_valid", 64'(creq.valid), 64'd1);
                    chk("gap_addr", creq.addr, line_addr);
                    chk("gap_len", 64'(creq.len), 64'(MLEN4));
                    check_resp_zero("gap_resp");
                end
            end
            @(negedge clk);
            cresp.ready = 1'b1;
            cresp.data  = b[k];
            cresp.last  = (k == 3);
            if (k == flush_beat) flush = 1'b1;
            @(posedge clk); #1;
            cresp.ready = 1'b0;
            cresp.last  = 1'b0;
            flush       = 1'b0;
        end
        chk("done_addr_ok", 64'(iresp.addr_ok), 64'd1);
        chk("done_data_ok", 64'(iresp.data_ok), 64'd1);
        chk("done_data", 64'(iresp.data), 64'(exp));
        chk("done_creq_idle", 64'(creq.valid), 64'd0);
        @(posedge clk); #1;
        ireq.valid = 1'b0;
    endtask

    task automatic uncached(input logic [63:0] a, input logic [63:0] beat, input logic [31:0] exp);
        @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = a;
        #1;
        chk("unc_no_resp", 64'(iresp.data_ok), 64'd0);
        wait_creq("unc_req_valid");
        chk("unc_addr",  creq.addr, a);
        chk("unc_size",  64'(creq.size), 64'(MSIZE4));
        chk("unc_len",   64'(creq.len), 64'(MLEN1));
        chk("unc_burst", 64'(creq.burst), 64'(AXI_BURST_FIXED));
        @(negedge clk);
        cresp.ready = 1'b1;
        cresp.data  = beat;
        cresp.last  = 1'b1;
        @(posedge clk); #1;
        cresp.ready = 1'b0;
        cresp.last  = 1'b0;
        chk("unc_data_ok", 64'(iresp.data_ok), 64'd1);
        chk("unc_data", 64'(iresp.data), 64'(exp));
        chk("unc_creq_idle", 64'(creq.valid), 64'd0);
        @(posedge clk); #1;
        ireq.valid = 1'b0;
    endtask

    task automatic hit(input logic [63:0] a, input logic [31:0] exp, input logic do_flush);
        @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = a;
        flush      = do_flush;
        #1;
        chk("hit_addr_ok", 64'(iresp.addr_ok), 64'd1);
        chk("hit_data_ok", 64'(iresp.data_ok), 64'd1);
        chk("hit_data", 64'(iresp.data), 64'(exp));
        @(posedge clk); #1;
        flush = 1'b0;
        chk("hit_no_bus", 64'(creq.valid), 64'd0);
        ireq.valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        ireq  = '0;
        cresp = '0;
        #3;
        chk("reset_creq", 64'(creq.valid), 64'd0);
        check_resp_zero("reset_resp");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle with an address present but valid low
        ireq.addr = 64'h8000_0000;
        @(posedge clk); #1;
        chk("idle_creq", 64'(creq.valid), 64'd0);
        check_resp_zero("idle_resp");

        // Cold miss, then hits in the same line
        fill(64'h8000_0004, A0, A1, A2, A3, 0, -1, 32'h1100_0001);
        hit(64'h8000_0018, 32'h4400_0006, 1'b0);
        hit(64'h8000_000C, 32'h2200_0003, 1'b0);

        // Conflict on index 0
        fill(64'h8000_0200, C0, C1, C2, C3, 0, -1, 32'h5500_0008);
        hit(64'h8000_0214, 32'h7700_000D, 1'b0);
        fill(64'h8000_0000, A0, A1, A2, A3, 0, -1, 32'h1100_0000);

        // Uncached fetches go to the bus every time and leave the array alone
        uncached(64'h0000_1000, 64'hDEAD_BEEF_CAFE_F00D, 32'hCAFE_F00D);
        uncached(64'h0000_1004, 64'hDEAD_BEEF_CAFE_F00D, 32'hDEAD_BEEF);
        hit(64'h8000_0000, 32'h1100_0000, 1'b0);

        // Flush in IDLE still serves the same-cycle hit, then the line misses
        hit(64'h8000_0008, 32'h2200_0002, 1'b1);
        fill(64'h8000_0008, A0, A1, A2, A3, 0, 1, 32'h2200_0002);
        // Flush during that refill leaves the line invalid
        fill(64'h8000_0008, A0, A1, A2, A3, 0, -1, 32'h2200_0002);
        hit(64'h8000_0008, 32'h2200_0002, 1'b0);

        // Ready with three-cycle gaps between beats
        fill(64'h8000_0044, D0, D1, D2, D3, 3, -1, 32'h9900_0011);
        hit(64'h8000_0058, 32'hCC00_0016, 1'b0);
        hit(64'h8000_0050, 32'hBB00_0014, 1'b0);
        hit(64'h8000_004C, 32'hAA00_0013, 1'b0);

        // Reset during beat 2 of a refill
        @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0060;
        wait_creq("rst_req_valid");
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            cresp.ready = 1'b1;
            cresp.data  = (k == 0) ? A0 : A1;
            @(posedge clk); #1;
            cresp.ready = 1'b0;
        end
        @(negedge clk);
        cresp.ready = 1'b1;
        cresp.data  = A2;
        reset       = 1'b1;
        ireq.valid  = 1'b0;
        #1;
        chk("rst_async_creq", 64'(creq.valid), 64'd0);
        check_resp_zero("rst_async_resp");
        cresp.ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        fill(64'h8000_0060, A0, A1, A2, A3, 0, -1, 32'h1100_0000);
        // Reset also invalidated the earlier lines
        fill(64'h8000_0044, D0, D1, D2, D3, 0, -1, 32'h9900_0011);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
